// File: rtl/video_timing_pkg.sv
// Shared raster constants, mode encoding and per-mode vertical landmarks for the
// Mega II / Super Hi-Res timing generator.
package video_timing_pkg;

    typedef enum logic {MODE_60 = 1'b0, MODE_50 = 1'b1} mode_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_BORDER_DEF = 104;
    localparam int H_FP_DEF     = 14;
    localparam int H_SYNC_DEF   = 56;
    localparam int H_TOTAL_DEF  = 912;
    localparam int H_VIS        = H_ACTIVE_DEF + H_BORDER_DEF;

    localparam int V_ACTIVE  = 200;
    localparam int B_BORDER  = 21;
    localparam int T_BORDER  = 19;
    localparam int V_FP      = 3;
    localparam int V_SYNC    = 4;
    localparam int VTOTAL_60 = 262;
    localparam int VTOTAL_50 = 312;

    localparam logic [9:0] V_SCAN       = 10'd256;
    localparam logic [9:0] V_END        = 10'd511;
    localparam logic [9:0] V_VIS_END    = 10'(int'(V_SCAN) + V_ACTIVE + B_BORDER - 1);
    localparam logic [9:0] V_SYNC_START = 10'(int'(V_VIS_END) + 1 + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(int'(V_SYNC_START) + V_SYNC - 1);
    localparam logic [9:0] V_MEGA2_VBL  = 10'd448;

    // The top border sits just before V_SCAN in scan order; when that reaches
    // below the frame's load value it wraps round to the end of the count.
    function automatic int tb_start(input int vtotal, input int tborder);
        int vload;
        int s;
        vload = int'(V_END) + 1 - vtotal;
        s     = int'(V_SCAN) - tborder;
        if (s < vload) s = s + vtotal;
        return s;
    endfunction

    localparam logic [9:0] V_LOAD_60   = 10'(int'(V_END) + 1 - VTOTAL_60);
    localparam logic [9:0] V_LOAD_50   = 10'(int'(V_END) + 1 - VTOTAL_50);
    localparam logic [9:0] TB_START_60 = 10'(tb_start(VTOTAL_60, T_BORDER));
    localparam logic [9:0] TB_START_50 = 10'(tb_start(VTOTAL_50, T_BORDER));

    function automatic logic [9:0] v_load(input mode_t m);
        return (m == MODE_50) ? V_LOAD_50 : V_LOAD_60;
    endfunction

endpackage

// File: rtl/video_vdecode.sv
// Combinational vertical decode: legacy line count plus mode to vblank, vsync
// and the Mega II VBL level.
module video_vdecode
    import video_timing_pkg::*;
(
    input  logic [9:0] i_vpos,
    input  mode_t      i_mode,
    output logic       o_vblank,
    output logic       o_vsync,
    output logic       o_mega2_vbl
);

    logic [9:0] w_tb_start;
    logic       w_active;
    logic       w_border;

    always_comb begin
        w_tb_start = (i_mode == MODE_50) ? TB_START_50 : TB_START_60;
        w_active   = (i_vpos >= V_SCAN) && (i_vpos <= V_VIS_END);
        // A border start at or above V_SCAN means it straddles the count wrap.
        if (w_tb_start >= V_SCAN)
            w_border = (i_vpos >= w_tb_start) || (i_vpos < V_SCAN);
        else
            w_border = (i_vpos >= w_tb_start) && (i_vpos < V_SCAN);
        o_vblank    = !(w_active || w_border);
        o_vsync     = !((i_vpos >= V_SYNC_START) && (i_vpos <= V_SYNC_END));
        o_mega2_vbl = (i_vpos >= V_MEGA2_VBL) || (i_vpos < V_SCAN);
    end

endmodule

// File: rtl/video_timing_gen.sv
// Dual-mode raster timing generator: h/v counters, frame mode latch, registered
// sync/blank decode and one-clock VBL, frame-start and scanline-compare pulses.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_BORDER = H_BORDER_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF
) (
    input  logic        i_clk_vid,
    input  logic        i_reset,
    input  logic        i_ce_pix,
    input  logic        i_mode_50hz,
    input  logic        i_line_cmp_en,
    input  logic [9:0]  i_line_cmp,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_hblank,
    output logic        o_vblank,
    output logic        o_mega2_vbl,
    output logic        o_vbl_pulse,
    output logic        o_line_irq,
    output logic        o_frame_start,
    output logic        o_mode_cur,
    output logic [10:0] o_hpos,
    output logic [9:0]  o_vpos
);

    localparam logic [10:0] L_H_VIS    = 11'(H_ACTIVE + H_BORDER);
    localparam logic [10:0] L_HS_START = 11'(H_ACTIVE + H_BORDER + H_FP);
    localparam logic [10:0] L_HS_END   = 11'(H_ACTIVE + H_BORDER + H_FP + H_SYNC - 1);
    localparam logic [10:0] L_H_LAST   = 11'(H_TOTAL - 1);

    logic [10:0] r_hpos;
    logic [9:0]  r_vpos;
    mode_t       r_mode;
    logic        r_hsync, r_hblank, r_vsync, r_vblank, r_mega2_vbl;
    logic        r_vbl_pulse, r_line_irq, r_frame_start;

    logic [10:0] w_hpos_nxt;
    logic [9:0]  w_vpos_nxt;
    mode_t       w_mode_nxt;
    logic        w_adv;
    logic        w_vblank_nxt, w_vsync_nxt, w_mega2_vbl_nxt;
    logic        w_vbl_pls, w_fs_pls, w_irq_pls;

    // Next-state counters; the decode below works on these so every level
    // output lands in the same register stage as the count it describes.
    always_comb begin
        w_hpos_nxt = r_hpos;
        w_vpos_nxt = r_vpos;
        w_mode_nxt = r_mode;
        w_adv      = 1'b0;
        if (i_reset) begin
            w_mode_nxt = mode_t'(i_mode_50hz);
            w_hpos_nxt = 11'd0;
            w_vpos_nxt = v_load(mode_t'(i_mode_50hz));
        end else if (i_ce_pix) begin
            w_adv = 1'b1;
            if (r_hpos == L_H_LAST) begin
                w_hpos_nxt = 11'd0;
                if (r_vpos == V_END) begin
                    w_mode_nxt = mode_t'(i_mode_50hz);
                    w_vpos_nxt = v_load(mode_t'(i_mode_50hz));
                end else begin
                    w_vpos_nxt = r_vpos + 10'd1;
                end
            end else begin
                w_hpos_nxt = r_hpos + 11'd1;
            end
        end
    end

    always_comb begin
        w_vbl_pls = w_adv && (w_hpos_nxt == 11'd0) && (w_vpos_nxt == V_MEGA2_VBL);
        w_fs_pls  = w_adv && (w_hpos_nxt == 11'd0) && (w_vpos_nxt == v_load(w_mode_nxt));
        w_irq_pls = w_adv && i_line_cmp_en && (w_hpos_nxt == L_H_VIS) &&
                    (w_vpos_nxt == i_line_cmp);
    end

    video_vdecode u_vdecode (
        .i_vpos      (w_vpos_nxt),
        .i_mode      (w_mode_nxt),
        .o_vblank    (w_vblank_nxt),
        .o_vsync     (w_vsync_nxt),
        .o_mega2_vbl (w_mega2_vbl_nxt)
    );

    always_ff @(posedge i_clk_vid) begin
        if (i_reset || i_ce_pix) begin
            r_hpos      <= w_hpos_nxt;
            r_vpos      <= w_vpos_nxt;
            r_mode      <= w_mode_nxt;
            r_hblank    <= (w_hpos_nxt >= L_H_VIS);
            r_hsync     <= !((w_hpos_nxt >= L_HS_START) && (w_hpos_nxt <= L_HS_END));
            r_vblank    <= w_vblank_nxt;
            r_vsync     <= w_vsync_nxt;
            r_mega2_vbl <= w_mega2_vbl_nxt;
        end
        // Pulse terms are already gated by reset and ce_pix, so they clear in gaps.
        r_vbl_pulse   <= w_vbl_pls;
        r_frame_start <= w_fs_pls;
        r_line_irq    <= w_irq_pls;
    end

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_mode_cur    = logic'(r_mode);
    assign o_hsync       = r_hsync;
    assign o_hblank      = r_hblank;
    assign o_vsync       = r_vsync;
    assign o_vblank      = r_vblank;
    assign o_mega2_vbl   = r_mega2_vbl;
    assign o_vbl_pulse   = r_vbl_pulse;
    assign o_frame_start = r_frame_start;
    assign o_line_irq    = r_line_irq;

endmodule
